// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit.
// A busy bit per register tracks long-latency destinations, and a counter
// tracks issued-but-unretired instructions. Decode stalls on RAW, WAW,
// in-flight-full and fence-drain hazards. The unit reports a one-hot stall
// cause and keeps a saturating count of stall cycles.
module hazard_scoreboard #(
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic [AW-1:0]    rs1addr_d,
  input  logic [AW-1:0]    rs2addr_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             wr_rd_d,
  input  logic             long_lat_d,
  input  logic             fence_d,
  input  logic             flush_d,
  input  logic             wb_valid_w,
  input  logic [AW-1:0]    wb_rd_w,
  input  logic             retire_m,
  output logic             stall_d,
  output logic [2:0]       stall_cause,
  output logic [IW-1:0]    inflight,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [NREGS-1:0] r_busy;
  logic [IW-1:0]    r_inflight;
  logic [CNT_W-1:0] r_stall_cycles;

  logic             w_slot_live;
  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_fence;
  logic             w_stall;
  logic [2:0]       w_cause;
  logic             w_issue;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_busy_nxt;
  logic [IW-1:0]    w_inflight_nxt;

  assign w_slot_live = valid_d && !flush_d;

  // Hazard terms evaluated against pre-update scoreboard state (no WB bypass)
  always_comb begin
    w_raw   = 1'b0;
    w_waw   = 1'b0;
    w_full  = 1'b0;
    w_fence = 1'b0;
    if (w_slot_live) begin
      w_raw   = (use_rs1_d && r_busy[rs1addr_d]) || (use_rs2_d && r_busy[rs2addr_d]);
      w_waw   = wr_rd_d && (rd_d != {AW{1'b0}}) && r_busy[rd_d];
      w_full  = (r_inflight == IW'(MAX_INFLIGHT)) && !fence_d;
      w_fence = fence_d && (r_inflight != {IW{1'b0}});
    end else begin
      w_raw   = 1'b0;
      w_waw   = 1'b0;
      w_full  = 1'b0;
      w_fence = 1'b0;
    end
  end

  // Stall and priority-encoded cause: fence > structural (waw/full) > raw
  always_comb begin
    w_stall = w_raw || w_waw || w_full || w_fence;
    w_cause = 3'b000;
    if (w_fence) begin
      w_cause = 3'b100;
    end else if (w_waw || w_full) begin
      w_cause = 3'b010;
    end else if (w_raw) begin
      w_cause = 3'b001;
    end else begin
      w_cause = 3'b000;
    end
  end

  assign stall_d     = w_stall;
  assign stall_cause = w_cause;
  assign w_issue     = w_slot_live && !w_stall;
  assign w_inc       = w_issue && !fence_d;
  assign w_dec       = retire_m && (r_inflight != {IW{1'b0}});

  // Next busy vector: writeback clear first, then issue set so set wins on a tie
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid_w && (wb_rd_w != {AW{1'b0}})) begin
      w_busy_nxt[wb_rd_w] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_issue && wr_rd_d && long_lat_d && (rd_d != {AW{1'b0}})) begin
      w_busy_nxt[rd_d] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Next in-flight count: issue and retire together cancel; retire at zero holds
  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_inc, w_dec})
      2'b10:   w_inflight_nxt = r_inflight + IW'(1);
      2'b01:   w_inflight_nxt = r_inflight - IW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // Scoreboard and in-flight state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= {NREGS{1'b0}};
      r_inflight <= {IW{1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  // Saturating stall-cycle performance counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign inflight     = r_inflight;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance plus a 4-bit
// counter instance driven by the same stimulus for saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d, use_rs1_d, use_rs2_d, wr_rd_d, long_lat_d;
  logic        fence_d, flush_d, wb_valid_w, retire_m;
  logic [4:0]  rs1addr_d, rs2addr_d, rd_d, wb_rd_w;
  logic        stall_d, s_stall_d;
  logic [2:0]  stall_cause, s_stall_cause;
  logic [2:0]  inflight, s_inflight;
  logic [31:0] stall_cycles;
  logic [3:0]  s_stall_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .rs1addr_d(rs1addr_d), .rs2addr_d(rs2addr_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd_d(rd_d), .wr_rd_d(wr_rd_d), .long_lat_d(long_lat_d),
    .fence_d(fence_d), .flush_d(flush_d),
    .wb_valid_w(wb_valid_w), .wb_rd_w(wb_rd_w), .retire_m(retire_m),
    .stall_d(stall_d), .stall_cause(stall_cause),
    .inflight(inflight), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .rs1addr_d(rs1addr_d), .rs2addr_d(rs2addr_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd_d(rd_d), .wr_rd_d(wr_rd_d), .long_lat_d(long_lat_d),
    .fence_d(fence_d), .flush_d(flush_d),
    .wb_valid_w(wb_valid_w), .wb_rd_w(wb_rd_w), .retire_m(retire_m),
    .stall_d(s_stall_d), .stall_cause(s_stall_cause),
    .inflight(s_inflight), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_d = 1'b0; use_rs1_d = 1'b0; use_rs2_d = 1'b0; wr_rd_d = 1'b0;
    long_lat_d = 1'b0; fence_d = 1'b0; flush_d = 1'b0; wb_valid_w = 1'b0;
    retire_m = 1'b0; rs1addr_d = 5'd0; rs2addr_d = 5'd0; rd_d = 5'd0; wb_rd_w = 5'd0;
  endtask

  // Protocol checks: no same-index set/clear, no retire with nothing in flight
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(valid_d && !flush_d && !stall_d && wr_rd_d && long_lat_d && rd_d != 5'd0
                && wb_valid_w && wb_rd_w == rd_d)) else begin
        fails++;
        $error("FAIL set_clear_same_idx: observed rd %0d expected no collision", rd_d);
      end
      assert (!(retire_m && inflight == 3'd0)) else begin
        fails++;
        $error("FAIL retire_at_zero: observed inflight %0d expected nonzero", inflight);
      end
    end
  end

  initial begin
    clr_in();
    rst_n = 1'b0;
    #3;
    chk("rst_stall", {31'd0, stall_d}, 32'd0);
    chk("rst_cause", {29'd0, stall_cause}, 32'd0);
    chk("rst_inflight", {29'd0, inflight}, 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // 1: load-use on x5
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd5; long_lat_d = 1'b1;
    #1 chk("t1_ld_issue", {31'd0, stall_d}, 32'd0);
    tick(); clr_in();
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1addr_d = 5'd5; wr_rd_d = 1'b1; rd_d = 5'd6;
    #1 chk("t1_inflight1", {29'd0, inflight}, 32'd1);
    chk("t1_raw_stall", {31'd0, stall_d}, 32'd1);
    chk("t1_raw_cause", {29'd0, stall_cause}, 32'd1);
    tick(); wb_valid_w = 1'b1; wb_rd_w = 5'd5;
    #1 chk("t1_wb_no_bypass", {31'd0, stall_d}, 32'd1);
    tick(); wb_valid_w = 1'b0;
    #1 chk("t1_released", {31'd0, stall_d}, 32'd0);
    chk("t1_cycles", stall_cycles, 32'd2);
    tick(); clr_in();
    #1 chk("t1_inflight2", {29'd0, inflight}, 32'd2);
    retire_m = 1'b1; tick(); tick(); retire_m = 1'b0;
    #1 chk("t1_drained", {29'd0, inflight}, 32'd0);

    // 2: WAW on x7
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd7; long_lat_d = 1'b1;
    tick(); clr_in();
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd7;
    #1 chk("t2_waw_stall", {31'd0, stall_d}, 32'd1);
    chk("t2_waw_cause", {29'd0, stall_cause}, 32'd2);
    tick(); wb_valid_w = 1'b1; wb_rd_w = 5'd7;
    #1 chk("t2_wb_cycle", {29'd0, stall_cause}, 32'd2);
    tick(); wb_valid_w = 1'b0;
    #1 chk("t2_released", {31'd0, stall_d}, 32'd0);
    chk("t2_cycles", stall_cycles, 32'd4);
    tick(); clr_in();
    #1 chk("t2_inflight2", {29'd0, inflight}, 32'd2);
    retire_m = 1'b1; tick(); tick(); retire_m = 1'b0;

    // 3: in-flight full
    valid_d = 1'b1;
    tick(); tick(); tick(); tick();
    #1 chk("t3_inflight4", {29'd0, inflight}, 32'd4);
    chk("t3_full_stall", {31'd0, stall_d}, 32'd1);
    chk("t3_full_cause", {29'd0, stall_cause}, 32'd2);
    tick(); retire_m = 1'b1;
    #1 chk("t3_full_retire", {31'd0, stall_d}, 32'd1);
    tick();
    #1 chk("t3_after_retire", {29'd0, inflight}, 32'd3);
    chk("t3_issue_ok", {31'd0, stall_d}, 32'd0);
    tick(); clr_in();
    #1 chk("t3_retire_issue", {29'd0, inflight}, 32'd3);

    // 4: fence drain with 3 in flight
    valid_d = 1'b1; fence_d = 1'b1;
    #1 chk("t4_fence_stall", {31'd0, stall_d}, 32'd1);
    chk("t4_fence_cause", {29'd0, stall_cause}, 32'd4);
    tick(); retire_m = 1'b1;
    tick(); tick(); tick(); retire_m = 1'b0;
    #1 chk("t4_fence_go", {31'd0, stall_d}, 32'd0);
    chk("t4_fence_cause0", {29'd0, stall_cause}, 32'd0);
    tick(); clr_in();
    #1 chk("t4_fence_nocount", {29'd0, inflight}, 32'd0);
    chk("t4_cycles", stall_cycles, 32'd10);

    // 5: x0 never tracked, flush suppresses, cause priority
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd0; long_lat_d = 1'b1;
    #1 chk("t5_x0_issue", {31'd0, stall_d}, 32'd0);
    tick(); clr_in();
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1addr_d = 5'd0;
    #1 chk("t5_x0_read", {31'd0, stall_d}, 32'd0);
    chk("t5_x0_busy", {31'd0, u_dut.r_busy[0]}, 32'd0);
    tick(); clr_in();
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd9; long_lat_d = 1'b1;
    tick(); clr_in();
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1addr_d = 5'd9; flush_d = 1'b1;
    #1 chk("t5_flush_stall", {31'd0, stall_d}, 32'd0);
    chk("t5_flush_cause", {29'd0, stall_cause}, 32'd0);
    tick(); flush_d = 1'b0;
    #1 chk("t5_flush_noissue", {29'd0, inflight}, 32'd3);
    chk("t5_raw_cause", {29'd0, stall_cause}, 32'd1);
    tick(); wr_rd_d = 1'b1; rd_d = 5'd9;
    #1 chk("t5_prio_struct", {29'd0, stall_cause}, 32'd2);
    tick(); fence_d = 1'b1;
    #1 chk("t5_prio_fence", {29'd0, stall_cause}, 32'd4);
    tick(); clr_in();
    #1 chk("t5_cycles", stall_cycles, 32'd13);

    // 6: async reset mid-operation, then saturation
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_inflight", {29'd0, inflight}, 32'd3 - 32'd3);
    chk("t6_rst_busy", u_dut.r_busy, 32'd0);
    chk("t6_rst_cycles", stall_cycles, 32'd0);
    chk("t6_rst_sat", {28'd0, s_stall_cycles}, 32'd0);
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1addr_d = 5'd9;
    #1 chk("t6_rst_nostall", {31'd0, stall_d}, 32'd0);
    #1 rst_n = 1'b1;
    clr_in(); wb_valid_w = 1'b1; wb_rd_w = 5'd9;
    tick(); clr_in();
    #1 chk("t6_late_wb", {29'd0, inflight}, 32'd0);
    valid_d = 1'b1; wr_rd_d = 1'b1; rd_d = 5'd3; long_lat_d = 1'b1;
    tick(); clr_in();
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1addr_d = 5'd3;
    repeat (20) tick();
    #1 chk("t6_sat_stall", {31'd0, stall_d}, 32'd1);
    chk("t6_sat_cnt4", {28'd0, s_stall_cycles}, 32'd15);
    chk("t6_cnt32", stall_cycles, 32'd20);
    clr_in(); wb_valid_w = 1'b1; wb_rd_w = 5'd3; retire_m = 1'b1;
    tick(); clr_in();
    #1 chk("t6_final_inflight", {29'd0, inflight}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
